bubble_timing_gen: RTL

BUBBLE_TIMING_GEN -- requirements
Module: bubble_timing_gen

---
 rtl/bubble_timing_gen.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bubble_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bubble_timing_gen                                            |
// | Description : Timing generator for a magnetic-bubble memory controller.    |
// |               Divides MCLK into CLKOUT, synchronises the bubble control    |
// |               strobes, runs the access state machine, the rotating-field   |
// |               phase counter, the absolute loop position and the            |
// |               invalid/valid quarter-tick counters of a transfer.           |
// |                                                                            |
// | Ports       : MCLK        in   system clock, all state on rising edge      |
// |               RST         in   asynchronous active-high reset              |
// |               nINCTRL     in   low = control strobes valid, high = all 1   |
// |               nBSS        in   bubble start/stop strobe, active low        |
// |               nBSEN       in   bubble shift enable, active low             |
// |               nREPEN      in   replicate enable, active low                |
// |               nBOOTEN     in   boot-loop enable, active low                |
// |               CLKOUT      out  MCLK / (2*MCLK_DIV), free running           |
// |               ACCTYPE     out  access state code (bit2 rotate, bit1 xfer)  |
// |               ABSPOS      out  absolute minor-loop position                |
// |               BOUTBITNUM  out  current output bit number                   |
// |               BOUTTICKS   out  quarter-cycle index within current bit      |
// |               BOUTVALID   out  BOUTBITNUM/BOUTTICKS are meaningful         |
// |               XFERDONE    out  one-MCLK pulse on the last quarter tick     |
// |               nMACT       out  low while the magnetic field rotates        |
// |                                                                            |
// | Config      : BUBBLE_INPUT_SYNC_EN defined   -> 4-stage input synchroniser |
// |               BUBBLE_INPUT_SYNC_EN undefined -> 1-stage input register     |
// |                                                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bubble_timing_gen #(
  parameter int MCLK_DIV       = 6,
  parameter int CYCLE_CLKS     = 480,
  parameter int LOOP_LEN       = 2053,
  parameter int INIT_POS       = LOOP_LEN - 2,
  parameter int INVALID_CYCLES = 98,
  parameter int BOOT_BITS      = 4106,
  parameter int PAGE_BITS      = 584,
  localparam int POS_W         = $clog2(LOOP_LEN),
  localparam int BIT_W         = $clog2((BOOT_BITS > PAGE_BITS) ? BOOT_BITS : PAGE_BITS)
) (
  input  logic             MCLK,
  input  logic             RST,
  input  logic             nINCTRL,
  input  logic             nBSS,
  input  logic             nBSEN,
  input  logic             nREPEN,
  input  logic             nBOOTEN,
  output logic             CLKOUT,
  output logic [2:0]       ACCTYPE,
  output logic [POS_W-1:0] ABSPOS,
  output logic [BIT_W-1:0] BOUTBITNUM,
  output logic [1:0]       BOUTTICKS,
  output logic             BOUTVALID,
  output logic             XFERDONE,
  output logic             nMACT
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
`ifdef BUBBLE_INPUT_SYNC_EN
  localparam int c_sync_depth = 4;
`else
  localparam int c_sync_depth = 1;
`endif

  localparam int c_div_w = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(MCLK_DIV - 1);

  localparam int c_ph_w = $clog2(CYCLE_CLKS);
  localparam logic [c_ph_w-1:0] c_ph_last = c_ph_w'(CYCLE_CLKS - 1);
  localparam logic [c_ph_w-1:0] c_ph_q1   = c_ph_w'(CYCLE_CLKS / 4);
  localparam logic [c_ph_w-1:0] c_ph_q2   = c_ph_w'(CYCLE_CLKS / 2);
  localparam logic [c_ph_w-1:0] c_ph_q3   = c_ph_w'((3 * CYCLE_CLKS) / 4);

  localparam logic [POS_W-1:0] c_pos_last = POS_W'(LOOP_LEN - 1);
  localparam logic [POS_W-1:0] c_pos_init = POS_W'(INIT_POS);

  localparam int c_inv_w = (INVALID_CYCLES > 0) ? $clog2(4 * INVALID_CYCLES + 1) : 1;
  localparam logic [c_inv_w-1:0] c_inv_max = c_inv_w'(4 * INVALID_CYCLES);

  // Valid-quarter count = {bit number, quarter index}
  localparam int c_val_w = BIT_W + 2;
  localparam logic [c_val_w-1:0] c_boot_last = c_val_w'(4 * BOOT_BITS - 1);
  localparam logic [c_val_w-1:0] c_boot_pen  = c_val_w'(4 * BOOT_BITS - 2);
  localparam logic [c_val_w-1:0] c_page_last = c_val_w'(4 * PAGE_BITS - 1);
  localparam logic [c_val_w-1:0] c_page_pen  = c_val_w'(4 * PAGE_BITS - 2);

  typedef enum logic [2:0] {
    ST_RST  = 3'b000,
    ST_STBY = 3'b001,
    ST_IDLE = 3'b100,
    ST_BOOT = 3'b110,
    ST_USER = 3'b111
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser. nINCTRL high forces every strobe inactive before the
  // first stage, so a masked input can never reach the state machine.
  // --------------------------------------------------------------------------
  logic [3:0]                    w_ctrl_raw;
  logic [c_sync_depth-1:0][3:0]  r_sync;
  logic                          w_bss;
  logic                          w_bsen;
  logic                          w_repen;
  logic                          w_booten;

  assign w_ctrl_raw = {nBSS, nBSEN, nREPEN, nBOOTEN} | {4{nINCTRL}};

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= w_ctrl_raw;
      for (int i = 1; i < c_sync_depth; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_bss    = r_sync[c_sync_depth-1][3];
  assign w_bsen   = r_sync[c_sync_depth-1][2];
  assign w_repen  = r_sync[c_sync_depth-1][1];
  assign w_booten = r_sync[c_sync_depth-1][0];

  // --------------------------------------------------------------------------
  // Clock divider
  // --------------------------------------------------------------------------
  logic [c_div_w-1:0] r_div;
  logic               r_clkout;

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_div    <= '0;
      r_clkout <= 1'b1;
    end else if (r_div == c_div_last) begin
      r_div    <= '0;
      r_clkout <= ~r_clkout;
    end else begin
      r_div    <= r_div + c_div_w'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Access state machine
  // --------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RST: begin
        if (!w_bss) w_state_nxt = ST_STBY;
      end
      // Standby ignores the abort combination and waits for shift enable.
      ST_STBY: begin
        if (w_bss && !w_bsen) w_state_nxt = w_booten ? ST_IDLE : ST_BOOT;
      end
      ST_IDLE: begin
        if (w_bss && w_bsen)  w_state_nxt = ST_RST;
        else if (!w_repen)    w_state_nxt = ST_USER;
      end
      ST_BOOT, ST_USER: begin
        if (w_bss && w_bsen)  w_state_nxt = ST_RST;
      end
      default: w_state_nxt = ST_RST;
    endcase
  end

  // --------------------------------------------------------------------------
  // Rotating-field phase and absolute position. Once started, the phase
  // counter always finishes its cycle so the field stops at a known angle.
  // --------------------------------------------------------------------------
  logic [c_ph_w-1:0] r_phase;
  logic [POS_W-1:0]  r_abspos;
  logic              w_ph_adv;
  logic              w_tick;

  assign w_ph_adv = r_state[2] | (r_phase != '0);
  assign w_tick   = w_ph_adv & ((r_phase == '0) || (r_phase == c_ph_q1) ||
                                (r_phase == c_ph_q2) || (r_phase == c_ph_q3));

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_phase  <= '0;
      r_abspos <= c_pos_init;
    end else if (w_ph_adv) begin
      if (r_phase == c_ph_last) begin
        r_phase  <= '0;
        r_abspos <= (r_abspos == c_pos_last) ? '0 : r_abspos + POS_W'(1);
      end else begin
        r_phase  <= r_phase + c_ph_w'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transfer quarter-tick counters. The first tick after the invalid window
  // only raises BOUTVALID so that bit 0 / quarter 0 is presented; later ticks
  // advance the valid count until the last quarter of the last bit.
  // --------------------------------------------------------------------------
  logic [c_inv_w-1:0] r_inv;
  logic [c_val_w-1:0] r_val;
  logic               r_valid;
  logic               r_xferdone;
  logic [c_val_w-1:0] w_val_last;
  logic [c_val_w-1:0] w_val_pen;

  assign w_val_last = (r_state == ST_USER) ? c_page_last : c_boot_last;
  assign w_val_pen  = (r_state == ST_USER) ? c_page_pen  : c_boot_pen;

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_inv      <= '0;
      r_val      <= '0;
      r_valid    <= 1'b0;
      r_xferdone <= 1'b0;
    end else begin
      r_xferdone <= 1'b0;
      if (!r_state[1]) begin
        r_inv   <= '0;
        r_val   <= '0;
        r_valid <= 1'b0;
      end else if (w_tick) begin
        if (r_inv < c_inv_max) begin
          r_inv <= r_inv + c_inv_w'(1);
        end else if (!r_valid) begin
          r_valid <= 1'b1;
        end else if (r_val != w_val_last) begin
          r_val <= r_val + c_val_w'(1);
          if (r_val == w_val_pen) r_xferdone <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign CLKOUT     = r_clkout;
  assign ACCTYPE    = r_state;
  assign ABSPOS     = r_abspos;
  assign BOUTBITNUM = r_val[c_val_w-1:2];
  assign BOUTTICKS  = r_val[1:0];
  assign BOUTVALID  = r_valid;
  assign XFERDONE   = r_xferdone;
  assign nMACT      = ~w_ph_adv;

endmodule
`default_nettype wire
